// File: rtl/npu_pkg.sv
// npu_pkg: shared state encoding and default latencies for the NPU conv scheduler
package npu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int ACC_LAT_D  = 20;
  localparam int POST_LAT_D = 4;
  localparam int CNT_W_D    = 16;
endpackage

// File: rtl/npu_tag_delay.sv
// npu_tag_delay: tag shift register with a mid tap and in-flight occupancy tracking
module npu_tag_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 24,
  parameter int TAP   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] dout,
  output logic             empty_next
);
  localparam int OW = $clog2(DEPTH + 2);
  logic [WIDTH-1:0] sr [DEPTH];
  logic [OW-1:0]    occ;
  logic [OW-1:0]    occ_nxt;
  assign tap        = sr[TAP-1];
  assign dout       = sr[DEPTH-1];
  assign occ_nxt    = occ + OW'(|din) - OW'(|dout);
  assign empty_next = occ_nxt == '0;
  // shift tags one stage per cycle and count non-empty entries in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      occ <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      occ <= occ_nxt;
    end
  end
endmodule

// File: rtl/npu_conv_scheduler.sv
// npu_conv_scheduler: sequences one conv layer pass through the MAC core
module npu_conv_scheduler
  import npu_pkg::*;
#(
  parameter int MAC_IN_NUM  = 9,
  parameter int MAC_OUT_NUM = 18,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_LAT     = ACC_LAT_D,
  parameter int POST_LAT    = POST_LAT_D,
  parameter int CNT_W       = CNT_W_D
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 cfg_acc_len,
  input  logic [CNT_W-1:0]                 cfg_pix_num,
  output logic                             busy,
  output logic                             done,
  input  logic [MAC_IN_NUM*DATA_WIDTH-1:0] src_data,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic [MAC_IN_NUM*DATA_WIDTH-1:0] core_data,
  output logic                             core_valid,
  output logic                             bias_gate,
  output logic [MAC_OUT_NUM-1:0]           adder_rst,
  output logic                             out_valid,
  output logic [CNT_W-1:0]                 pix_idx
);
  state_t           state;
  logic [CNT_W-1:0] acc_len, pix_num, beat_cnt, pix_cnt, out_cnt;
  logic             run, acc, first, last, last_pix, empty_next;
  logic [1:0]       tap, dout;
  assign run        = state == RUN;
  assign acc        = run & src_valid;
  assign first      = beat_cnt == '0;
  assign last       = beat_cnt == acc_len - CNT_W'(1);
  assign last_pix   = pix_cnt == pix_num - CNT_W'(1);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign src_ready  = run;
  assign core_valid = run;
  assign core_data  = acc ? src_data : '0;
  assign bias_gate  = ~(acc & first);
  assign adder_rst  = {MAC_OUT_NUM{tap[1]}};
  assign out_valid  = dout[0];
  assign pix_idx    = out_cnt;

  npu_tag_delay #(.WIDTH(2), .DEPTH(ACC_LAT + POST_LAT), .TAP(ACC_LAT)) u_tag (
    .clk        (clk),
    .rst        (rst),
    .din        ({acc & first, acc & last}),
    .tap        (tap),
    .dout       (dout),
    .empty_next (empty_next)
  );

  // layer FSM with beat/pixel counters and output pixel index
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc_len  <= '0;
      pix_num  <= '0;
      beat_cnt <= '0;
      pix_cnt  <= '0;
      out_cnt  <= '0;
    end else begin
      if (out_valid) out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        IDLE: if (start) begin
          acc_len  <= cfg_acc_len == '0 ? CNT_W'(1) : cfg_acc_len;
          pix_num  <= cfg_pix_num;
          beat_cnt <= '0;
          pix_cnt  <= '0;
          out_cnt  <= '0;
          state    <= cfg_pix_num == '0 ? DONE : RUN;
        end
        RUN: if (acc) begin
          beat_cnt <= last ? '0 : beat_cnt + CNT_W'(1);
          if (last) pix_cnt <= pix_cnt + CNT_W'(1);
          if (last && last_pix) state <= DRAIN;
        end
        DRAIN: if (out_valid && empty_next) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
